// File: rtl/fifo_burst_pkg.sv
// Shared definitions for the FIFO burst drain block.
//   - burst_state_e : two-state framing FSM encoding (IDLE, ACTIVE)
//   - cnt_width()   : counter width helper that never returns zero
//   - DEF_*         : default parameter values and the counter widths they imply
package fifo_burst_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } burst_state_e;

    // $clog2(1) is 0, which would leave a counter with no bits.
    // A counter therefore always gets at least one bit.
    function automatic int cnt_width(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

    localparam int DEF_FIFO_WIDTH = 8;
    localparam int DEF_BURST_LEN  = 4;
    localparam int DEF_TIMEOUT    = 8;
    localparam int DEF_BEAT_W     = cnt_width(DEF_BURST_LEN);
    localparam int DEF_IDLE_W     = cnt_width(DEF_TIMEOUT + 1);

endpackage

// File: rtl/fifo_burst_drain.sv
// Drains a show-ahead synchronous FIFO and re-emits its words as framed bursts
// on a valid/ready stream.
//
// One word is always held in a pending slot. This lets the block decide
// whether that word is the last beat before it is emitted. A burst closes
// under any of these conditions:
//   - after BURST_LEN beats;
//   - after TIMEOUT consecutive FIFO-empty cycles with a word held;
//   - on flush.
//
// Ports:
//   fifo_clk, fifo_rst_n  clock, asynchronous active-low reset
//   fifo_empty            upstream FIFO empty
//   fifo_rdata            upstream head word (valid while fifo_empty=0)
//   fifo_ren              pop request (combinational)
//   flush                 close the current burst at the next opportunity
//   m_valid/m_ready       output handshake (m_valid registered)
//   m_data                output beat data (registered)
//   m_sop, m_eop          first / last beat of a burst (registered)
module fifo_burst_drain
    import fifo_burst_pkg::*;
#(
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int BURST_LEN  = DEF_BURST_LEN,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                  fifo_clk,
    input  logic                  fifo_rst_n,
    input  logic                  fifo_empty,
    input  logic [FIFO_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_ren,
    input  logic                  flush,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_sop,
    output logic                  m_eop
);

    localparam int BEAT_W = cnt_width(BURST_LEN);
    localparam int IDLE_W = cnt_width(TIMEOUT + 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT);

    burst_state_e          state_r;
    burst_state_e          state_nxt_s;
    logic                  pend_vld_r;
    logic [FIFO_WIDTH-1:0] pend_data_r;
    logic [BEAT_W-1:0]     beat_cnt_r;
    logic [IDLE_W-1:0]     idle_cnt_r;

    logic                  out_free_s;
    logic                  timed_out_s;
    logic                  last_s;
    logic                  move_s;
    logic                  pop_s;

    // Control terms.
    // A non-final move needs a successor word already in the FIFO, so that
    // eop can never be left pending on a beat that has already been emitted.
    // The timeout term also needs the FIFO to be empty. A word arriving on
    // the timeout cycle therefore extends the burst instead of closing it.
    assign out_free_s  = !m_valid || m_ready;
    assign timed_out_s = (idle_cnt_r == IDLE_MAX) && fifo_empty;
    assign last_s      = (beat_cnt_r == BEAT_LAST) || flush || timed_out_s;
    assign move_s      = pend_vld_r && out_free_s && (last_s || !fifo_empty);

    // Pop only when the FIFO has data, so the FIFO never reads through a
    // simultaneous write. Popping is also suppressed while reset is
    // asserted, so that no word is lost during reset.
    assign pop_s    = fifo_rst_n && !fifo_empty && (!pend_vld_r || move_s);
    assign fifo_ren = pop_s;

    // FSM state register
    always_ff @(posedge fifo_clk or negedge fifo_rst_n) begin
        if (!fifo_rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: leave ACTIVE only when the held word closes the burst
    // and no new word replaces it in the same cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (pop_s) begin
                    state_nxt_s = ACTIVE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACTIVE: begin
                if (move_s && last_s && !pop_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = ACTIVE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Pending slot: load on pop, empty when its word moves out without a refill
    always_ff @(posedge fifo_clk or negedge fifo_rst_n) begin
        if (!fifo_rst_n) begin
            pend_vld_r  <= 1'b0;
            pend_data_r <= {FIFO_WIDTH{1'b0}};
        end else if (pop_s) begin
            pend_vld_r  <= 1'b1;
            pend_data_r <= fifo_rdata;
        end else if (move_s) begin
            pend_vld_r  <= 1'b0;
        end
    end

    // Output register: held under backpressure, cleared once the beat is taken
    always_ff @(posedge fifo_clk or negedge fifo_rst_n) begin
        if (!fifo_rst_n) begin
            m_valid <= 1'b0;
            m_data  <= {FIFO_WIDTH{1'b0}};
            m_sop   <= 1'b0;
            m_eop   <= 1'b0;
        end else if (move_s) begin
            m_valid <= 1'b1;
            m_data  <= pend_data_r;
            m_sop   <= (beat_cnt_r == {BEAT_W{1'b0}});
            m_eop   <= last_s;
        end else if (out_free_s) begin
            m_valid <= 1'b0;
        end
    end

    // Beat counter: position of the next beat within the current burst
    always_ff @(posedge fifo_clk or negedge fifo_rst_n) begin
        if (!fifo_rst_n) begin
            beat_cnt_r <= {BEAT_W{1'b0}};
        end else if (move_s) begin
            if (last_s) begin
                beat_cnt_r <= {BEAT_W{1'b0}};
            end else begin
                beat_cnt_r <= beat_cnt_r + BEAT_W'(1);
            end
        end
    end

    // Idle counter: counts FIFO-empty cycles while a word is held.
    // It saturates at TIMEOUT and keeps counting even while the output is
    // stalled.
    always_ff @(posedge fifo_clk or negedge fifo_rst_n) begin
        if (!fifo_rst_n) begin
            idle_cnt_r <= {IDLE_W{1'b0}};
        end else if (pop_s || move_s) begin
            idle_cnt_r <= {IDLE_W{1'b0}};
        end else if (pend_vld_r && fifo_empty && (idle_cnt_r != IDLE_MAX)) begin
            idle_cnt_r <= idle_cnt_r + IDLE_W'(1);
        end
    end

endmodule

// File: tb/tb_fifo_burst_drain.sv
// Directed bench for fifo_burst_drain (FIFO_WIDTH=8, BURST_LEN=4, TIMEOUT=8).
// A small show-ahead FIFO model sits ahead of the DUT.
// A negedge monitor logs every accepted beat with its cycle stamp, and the
// stimulus checks that log against hand-computed sequences.
module tb_fifo_burst_drain;

    logic       fifo_clk;
    logic       fifo_rst_n;
    logic       fifo_empty;
    logic [7:0] fifo_rdata;
    logic       fifo_ren;
    logic       flush;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_sop;
    logic       m_eop;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Upstream show-ahead FIFO model: stimulus writes, DUT pops
    logic [7:0] fmem [0:63];
    int wp = 0;
    int rp = 0;
    assign fifo_empty = (wp == rp);
    assign fifo_rdata = fmem[rp[5:0]];

    // Accepted-beat log
    logic [7:0] ld [0:63];
    logic       ls [0:63];
    logic       le [0:63];
    int         lc [0:63];
    int         nbeats = 0;

    fifo_burst_drain #(
        .FIFO_WIDTH (8),
        .BURST_LEN  (4),
        .TIMEOUT    (8)
    ) dut (
        .fifo_clk   (fifo_clk),
        .fifo_rst_n (fifo_rst_n),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_ren   (fifo_ren),
        .flush      (flush),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_sop      (m_sop),
        .m_eop      (m_eop)
    );

    initial fifo_clk = 1'b0;
    always #5 fifo_clk = ~fifo_clk;

    always @(posedge fifo_clk) begin
        cyc <= cyc + 1;
        if (fifo_ren) begin
            rp <= rp + 1;
        end
    end

    // m_ready only changes just after a rising edge, so what is seen here
    // is what the next rising edge accepts.
    always @(negedge fifo_clk) begin
        if (fifo_rst_n && m_valid && m_ready) begin
            ld[nbeats[5:0]] = m_data;
            ls[nbeats[5:0]] = m_sop;
            le[nbeats[5:0]] = m_eop;
            lc[nbeats[5:0]] = cyc;
            nbeats = nbeats + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        fmem[wp[5:0]] = d;
        wp = wp + 1;
    endtask

    task automatic wait_beats(input string tag, input int target, input int budget);
        int k;
        k = 0;
        while (nbeats < target && k < budget) begin
            @(posedge fifo_clk);
            k++;
        end
        @(negedge fifo_clk);
        check(tag, nbeats, target);
    endtask

    task automatic check_beat(input string tag, input int idx, input logic [7:0] d,
                              input logic s, input logic e);
        check({tag, "_data"}, ld[idx[5:0]], d);
        check({tag, "_sop"},  ls[idx[5:0]], s);
        check({tag, "_eop"},  le[idx[5:0]], e);
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge fifo_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        fifo_rst_n = 1'b0;
        m_ready    = 1'b1;
        flush      = 1'b0;

        // Reset state
        @(negedge fifo_clk);
        check("rst_valid", m_valid, 1'b0);
        check("rst_data",  m_data,  8'h00);
        check("rst_sop",   m_sop,   1'b0);
        check("rst_eop",   m_eop,   1'b0);
        check("rst_ren",   fifo_ren, 1'b0);
        @(posedge fifo_clk);
        #1 fifo_rst_n = 1'b1;
        gap(2);

        // 1: full bursts, 1 beat/cycle
        base = nbeats;
        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
        wait_beats("t1_beats", base + 8, 40);
        for (int i = 0; i < 8; i++) begin
            check_beat("t1", base + i, 8'h10 + 8'(i), (i % 4) == 0, (i % 4) == 3);
            check("t1_cycle", lc[(base + i) % 64] - lc[base % 64], i);
        end
        gap(3);

        // 2: timeout close, A2 emitted 9 cycles after A1
        base = nbeats;
        push(8'hA0); push(8'hA1); push(8'hA2);
        wait_beats("t2_beats", base + 3, 40);
        check_beat("t2_a0", base,     8'hA0, 1'b1, 1'b0);
        check_beat("t2_a1", base + 1, 8'hA1, 1'b0, 1'b0);
        check_beat("t2_a2", base + 2, 8'hA2, 1'b0, 1'b1);
        check("t2_a0a1_gap", lc[(base + 1) % 64] - lc[base % 64], 1);
        check("t2_timeout_gap", lc[(base + 2) % 64] - lc[(base + 1) % 64], 9);
        gap(2);
        @(negedge fifo_clk);
        check("t2_idle_valid", m_valid, 1'b0);
        gap(2);

        // 3: backpressure on beat 2
        base = nbeats;
        for (int i = 0; i < 6; i++) push(8'h30 + 8'(i));
        gap(3);
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge fifo_clk);
            check("t3_hold_valid", m_valid, 1'b1);
            check("t3_hold_data",  m_data,  8'h31);
            check("t3_hold_sop",   m_sop,   1'b0);
            check("t3_hold_eop",   m_eop,   1'b0);
            check("t3_hold_ren",   fifo_ren, 1'b0);
        end
        @(posedge fifo_clk);
        #1 m_ready = 1'b1;
        wait_beats("t3_beats", base + 6, 60);
        for (int i = 0; i < 6; i++) begin
            check_beat("t3", base + i, 8'h30 + 8'(i), (i == 0) || (i == 4), (i == 3) || (i == 5));
        end
        gap(3);

        // 4: late arrival on the timeout cycle extends the burst
        base = nbeats;
        push(8'hB0);
        gap(9);
        push(8'hB1);
        wait_beats("t4_beats", base + 2, 40);
        check_beat("t4_b0", base,     8'hB0, 1'b1, 1'b0);
        check_beat("t4_b1", base + 1, 8'hB1, 1'b0, 1'b1);
        gap(3);

        // 5: flush with a pending word, then flush in IDLE
        base = nbeats;
        push(8'hC0);
        @(posedge fifo_clk);
        #1 flush = 1'b1;
        @(posedge fifo_clk);
        #1 flush = 1'b0;
        @(negedge fifo_clk);
        check("t5_valid", m_valid, 1'b1);
        check("t5_data",  m_data,  8'hC0);
        check("t5_sop",   m_sop,   1'b1);
        check("t5_eop",   m_eop,   1'b1);
        gap(3);
        flush = 1'b1;
        gap(1);
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge fifo_clk);
            check("t5_idle_valid", m_valid, 1'b0);
        end
        check("t5_beats", nbeats, base + 1);
        gap(1);

        // 6: reset mid-burst; D2 (output) and D3 (pending) are discarded
        base = nbeats;
        for (int i = 0; i < 6; i++) push(8'hD0 + 8'(i));
        gap(4);
        fifo_rst_n = 1'b0;
        @(negedge fifo_clk);
        check("t6_rst_valid", m_valid, 1'b0);
        check("t6_rst_data",  m_data,  8'h00);
        check("t6_rst_sop",   m_sop,   1'b0);
        check("t6_rst_eop",   m_eop,   1'b0);
        check("t6_rst_ren",   fifo_ren, 1'b0);
        gap(2);
        fifo_rst_n = 1'b1;
        wait_beats("t6_beats", base + 4, 40);
        check_beat("t6_d0", base,     8'hD0, 1'b1, 1'b0);
        check_beat("t6_d1", base + 1, 8'hD1, 1'b0, 1'b0);
        check_beat("t6_d4", base + 2, 8'hD4, 1'b1, 1'b0);
        check_beat("t6_d5", base + 3, 8'hD5, 1'b0, 1'b1);

        gap(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
